// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage load/store unit: exception codes, access
// size encodings, default address map, bus payload structs and lane helpers.
package mem_access_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned EXC_W    = 5;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DEF_NWIN = 4;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Default map: data memory, timer 1, timer 2, interrupt generator
    localparam logic [XLEN-1:0] DM_START  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DM_END    = 32'h0000_2fff;
    localparam logic [XLEN-1:0] TC1_START = 32'h0000_7f00;
    localparam logic [XLEN-1:0] TC1_END   = 32'h0000_7f0b;
    localparam logic [XLEN-1:0] TC2_START = 32'h0000_7f10;
    localparam logic [XLEN-1:0] TC2_END   = 32'h0000_7f1b;
    localparam logic [XLEN-1:0] IG_START  = 32'h0000_7f20;
    localparam logic [XLEN-1:0] IG_END    = 32'h0000_7f23;

    localparam logic [DEF_NWIN*XLEN-1:0] DEF_WIN_BASE = {IG_START, TC2_START, TC1_START, DM_START};
    localparam logic [DEF_NWIN*XLEN-1:0] DEF_WIN_LAST = {IG_END, TC2_END, TC1_END, DM_END};
    localparam logic [DEF_NWIN-1:0]      DEF_WORDONLY = 4'b0110;
    localparam logic [DEF_NWIN-1:0]      DEF_RO       = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Registered bus request payload
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
        logic            we;
    } bus_req_t;

    // Load formatting context captured when the access is accepted
    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] lane;
    } ld_ctl_t;

    // Byte enables for a store; size 11 behaves as word
    function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size,
                                                     input logic [1:0] lane);
        logic [BE_W-1:0] be;
        case (size)
            SIZE_BYTE: be = BE_W'(4'b0001 << lane);
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes it may land on
    function automatic logic [XLEN-1:0] store_data(input logic [1:0]      size,
                                                   input logic [XLEN-1:0] data);
        logic [XLEN-1:0] d;
        case (size)
            SIZE_BYTE: d = {4{data[7:0]}};
            SIZE_HALF: d = {2{data[15:0]}};
            default:   d = data;
        endcase
        return d;
    endfunction

    // Select the addressed lane and sign/zero extend it
    function automatic logic [XLEN-1:0] load_extend(input logic [1:0]      size,
                                                    input logic            is_unsigned,
                                                    input logic [1:0]      lane,
                                                    input logic [XLEN-1:0] word);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] d;
        sh = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: d = is_unsigned ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: d = is_unsigned ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default:   d = sh;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_unit_access_checker.sv
// Combinational access checker: window decode (lowest index wins on overlap)
// and fault detection for misalignment, unmapped, word-only and read-only.
// Ports:
//   i_addr   byte address of the access
//   i_size   00 byte, 01 half, 10/11 word
//   i_store  access is a store
//   o_fault  access must raise AdEL/AdES
module mem_access_unit_access_checker
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned               NWIN         = DEF_NWIN,
    parameter logic [NWIN*XLEN-1:0]      WIN_BASE     = DEF_WIN_BASE,
    parameter logic [NWIN*XLEN-1:0]      WIN_LAST     = DEF_WIN_LAST,
    parameter logic [NWIN-1:0]           WIN_WORDONLY = DEF_WORDONLY,
    parameter logic [NWIN-1:0]           WIN_RO       = DEF_RO
) (
    input  logic [XLEN-1:0] i_addr,
    input  logic [1:0]      i_size,
    input  logic            i_store,
    output logic            o_fault
);

    logic w_hit;
    logic w_wordonly;
    logic w_ro;
    logic w_misalign;

    // Walk from the highest index down so the lowest matching window wins
    always_comb begin
        w_hit      = 1'b0;
        w_wordonly = 1'b0;
        w_ro       = 1'b0;
        for (int i = int'(NWIN) - 1; i >= 0; i--) begin
            if (i_addr >= WIN_BASE[i*XLEN +: XLEN] && i_addr <= WIN_LAST[i*XLEN +: XLEN]) begin
                w_hit      = 1'b1;
                w_wordonly = WIN_WORDONLY[i];
                w_ro       = WIN_RO[i];
            end
        end
    end

    always_comb begin
        w_misalign = 1'b0;
        if (i_size == SIZE_HALF) begin
            w_misalign = i_addr[0];
        end else if (i_size[1]) begin
            w_misalign = |i_addr[1:0];
        end
    end

    assign o_fault = w_misalign | ~w_hit | (w_wordonly & ~i_size[1]) | (w_ro & i_store);

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: checks each access, issues a req/ack bus
// transaction, stalls the pipeline while it is outstanding and returns
// extended load data or an exception code.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   op_load/op_store/op_size/op_unsigned/addr/wdata   M-stage access
//   flush                      blocks acceptance of a new access
//   stall                      freeze F/D/E/M (combinational)
//   rdata/rdata_valid          load result in DONE
//   exc_valid/exc_code         AdEL/AdES in cycle 0, bus error in DONE
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bridge request
//   bus_ack/bus_rdata          bridge completion
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned          NWIN         = DEF_NWIN,
    parameter logic [NWIN*XLEN-1:0] WIN_BASE     = DEF_WIN_BASE,
    parameter logic [NWIN*XLEN-1:0] WIN_LAST     = DEF_WIN_LAST,
    parameter logic [NWIN-1:0]      WIN_WORDONLY = DEF_WORDONLY,
    parameter logic [NWIN-1:0]      WIN_RO       = DEF_RO,
    parameter int unsigned          TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   rdata,
    output logic              rdata_valid,
    output logic              exc_valid,
    output logic [EXC_W-1:0]  exc_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    state_e           r_state;
    state_e           w_state_next;
    bus_req_t         r_bus;
    logic             r_bus_req;
    ld_ctl_t          r_ld;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [XLEN-1:0]  r_rdata;
    logic             r_rdata_valid;
    logic             r_timeout;

    logic             w_access;
    logic             w_fault;
    logic             w_accept;
    logic             w_timeout_hit;
    logic             w_stall;
    logic             w_exc_valid;
    logic [EXC_W-1:0] w_exc_code;

    assign w_access = op_load | op_store;

    mem_access_unit_access_checker #(
        .NWIN         (NWIN),
        .WIN_BASE     (WIN_BASE),
        .WIN_LAST     (WIN_LAST),
        .WIN_WORDONLY (WIN_WORDONLY),
        .WIN_RO       (WIN_RO)
    ) u_checker (
        .i_addr  (addr),
        .i_size  (op_size),
        .i_store (op_store),
        .o_fault (w_fault)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, stall and exception reporting
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_stall       = 1'b0;
        w_exc_valid   = 1'b0;
        w_exc_code    = EXC_NONE;
        w_timeout_hit = 1'b0;
        w_cnt_next    = r_cnt + CNT_W'(1);
        case (r_state)
            ST_IDLE: begin
                if (w_access && w_fault) begin
                    w_exc_valid = 1'b1;
                    w_exc_code  = op_store ? EXC_ADES : EXC_ADEL;
                end else if (w_access && !flush) begin
                    w_accept     = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                // An ack in the same cycle as the limit takes priority
                w_timeout_hit = !bus_ack && (w_cnt_next == CNT_W'(TIMEOUT));
                if (bus_ack || w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                if (r_timeout) begin
                    w_exc_valid = 1'b1;
                    w_exc_code  = EXC_DBE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus request, wait counter and load result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bus         <= '0;
            r_bus_req     <= 1'b0;
            r_ld          <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt         <= '0;
                    r_rdata_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                    if (w_accept) begin
                        r_bus.addr     <= {addr[XLEN-1:2], 2'b00};
                        r_bus.be       <= op_store ? byte_enables(op_size, addr[1:0]) : '0;
                        r_bus.wdata    <= op_store ? store_data(op_size, wdata) : '0;
                        r_bus.we       <= op_store;
                        r_bus_req      <= 1'b1;
                        r_ld.is_load     <= op_load;
                        r_ld.size        <= op_size;
                        r_ld.is_unsigned <= op_unsigned;
                        r_ld.lane        <= addr[1:0];
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        r_bus         <= '0;
                        r_bus_req     <= 1'b0;
                        r_rdata_valid <= r_ld.is_load;
                        if (r_ld.is_load) begin
                            r_rdata <= load_extend(r_ld.size, r_ld.is_unsigned, r_ld.lane, bus_rdata);
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout_hit) begin
                            r_bus     <= '0;
                            r_bus_req <= 1'b0;
                            r_timeout <= 1'b1;
                            if (r_ld.is_load) begin
                                r_rdata <= '0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_rdata_valid <= 1'b0;
                    r_timeout     <= 1'b0;
                end
                default: begin
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall       = w_stall;
    assign exc_valid   = w_exc_valid;
    assign exc_code    = w_exc_code;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus.we;
    assign bus_addr    = r_bus.addr;
    assign bus_be      = r_bus.be;
    assign bus_wdata   = r_bus.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=3 and the default map.
module tb_mem_access_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk;
    logic        reset;
    logic        op_load;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_load     (op_load),
        .op_store    (op_store),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an access on the inputs just after a falling edge
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        op_load = ld; op_store = st; op_size = sz; op_unsigned = uns; addr = a; wdata = wd;
        #1;
    endtask

    task automatic clear_ops();
        op_load = 1'b0; op_store = 1'b0;
    endtask

    // Accept, ack on first BUSY cycle with rd, end sampling in DONE
    task automatic load_ack_first(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                                  input logic [31:0] rd);
        issue(1'b1, 1'b0, sz, uns, a, 32'h0);
        @(negedge clk);
        clear_ops();
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, bus_req, bus_we, rdata_valid, exc_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 00000", {stall, bus_req, bus_we, rdata_valid, exc_valid});
        end
        checks++;
        if ({bus_addr, bus_be, bus_wdata, rdata, exc_code} !== 105'b0) begin
            errors++; $display("FAIL reset_data got addr %h be %b wd %h rd %h code %0d", bus_addr, bus_be, bus_wdata, rdata, exc_code);
        end
        reset = 1'b1;
    endtask

    task automatic test_load_word();
        int stalls;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0100, 32'h0);
        stalls = stall ? 1 : 0;
        checks++;
        if (exc_valid !== 1'b0) begin errors++; $display("FAIL lw_noexc got %b want 0", exc_valid); end
        @(negedge clk);
        clear_ops();
        if (stall) stalls++;
        checks++;
        if ({bus_req, bus_we, bus_be} !== 6'b10_0000) begin
            errors++; $display("FAIL lw_bus got req/we/be %b want 100000", {bus_req, bus_we, bus_be});
        end
        checks++;
        if (bus_addr !== 32'h0000_0100) begin errors++; $display("FAIL lw_addr got %h want 00000100", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h8765_4321;
        @(negedge clk);
        bus_ack = 1'b0;
        if (stall) stalls++;
        checks++;
        if (rdata !== 32'h8765_4321 || rdata_valid !== 1'b1) begin
            errors++; $display("FAIL lw_rdata got %h/%b want 87654321/1", rdata, rdata_valid);
        end
        checks++;
        if (bus_req !== 1'b0 || exc_valid !== 1'b0) begin
            errors++; $display("FAIL lw_done got req %b exc %b want 0 0", bus_req, exc_valid);
        end
        checks++;
        if (stalls !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d want 2", stalls); end
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL lw_valid_drop got %b want 0", rdata_valid); end
    endtask

    task automatic test_load_extend();
        load_ack_first(SZ_B, 1'b0, 32'h0000_0103, 32'h80FF_FF00);
        checks++;
        if (rdata !== 32'hFFFF_FF80 || rdata_valid !== 1'b1) begin
            errors++; $display("FAIL lb got %h/%b want ffffff80/1", rdata, rdata_valid);
        end
        load_ack_first(SZ_B, 1'b1, 32'h0000_0103, 32'h80FF_FF00);
        checks++;
        if (rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", rdata); end
        load_ack_first(SZ_H, 1'b0, 32'h0000_0102, 32'h80FF_FF00);
        checks++;
        if (rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh got %h want ffff80ff", rdata); end
        load_ack_first(SZ_H, 1'b1, 32'h0000_0100, 32'h80FF_8F00);
        checks++;
        if (rdata !== 32'h0000_8F00) begin errors++; $display("FAIL lhu got %h want 00008f00", rdata); end
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL sh_stall got %b want 1", stall); end
        @(negedge clk);
        clear_ops();
        checks++;
        if ({bus_req, bus_we, bus_be} !== 6'b11_1100 || bus_wdata !== 32'hABCD_ABCD || bus_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL sh_bus got req/we/be %b wd %h addr %h want 111100 abcdabcd 00000100", {bus_req, bus_we, bus_be}, bus_wdata, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (rdata_valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL sh_done got valid %b stall %b want 0 0", rdata_valid, stall);
        end
        issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_0101, 32'h0000_005A);
        @(negedge clk);
        clear_ops();
        checks++;
        if (bus_be !== 4'b0010 || bus_wdata !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL sb_bus got be %b wd %h want 0010 5a5a5a5a", bus_be, bus_wdata);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic test_faults();
        logic [31:0] f_addr [3];
        logic        f_st   [3];
        logic [1:0]  f_sz   [3];
        logic [4:0]  f_code [3];
        f_addr[0] = 32'h0000_7f01; f_st[0] = 1'b0; f_sz[0] = SZ_H; f_code[0] = 5'd4;
        f_addr[1] = 32'h0000_7f04; f_st[1] = 1'b1; f_sz[1] = SZ_B; f_code[1] = 5'd5;
        f_addr[2] = 32'h0000_4000; f_st[2] = 1'b0; f_sz[2] = SZ_W; f_code[2] = 5'd4;
        for (int i = 0; i < 3; i++) begin
            issue(~f_st[i], f_st[i], f_sz[i], 1'b0, f_addr[i], 32'h0);
            checks++;
            if (exc_valid !== 1'b1 || exc_code !== f_code[i] || stall !== 1'b0) begin
                errors++; $display("FAIL fault%0d got exc %b code %0d stall %b want 1 %0d 0", i, exc_valid, exc_code, stall, f_code[i]);
            end
            @(negedge clk);
            checks++;
            if (bus_req !== 1'b0) begin errors++; $display("FAIL fault%0d_noreq got %b want 0", i, bus_req); end
            clear_ops();
            #1;
            checks++;
            if (exc_valid !== 1'b0 || exc_code !== 5'd0) begin
                errors++; $display("FAIL fault%0d_clear got %b/%0d want 0/0", i, exc_valid, exc_code);
            end
        end
    endtask

    task automatic test_timeout_flush();
        int busy;
        busy = 0;
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0200, 32'h0);
        @(negedge clk);
        clear_ops();
        for (int k = 0; k < 20; k++) begin
            if (!bus_req) break;
            busy++;
            flush = (k == 0);
            @(negedge clk);
        end
        flush = 1'b0;
        checks++;
        if (busy !== 3) begin errors++; $display("FAIL to_busy_cycles got %0d want 3", busy); end
        checks++;
        if (exc_valid !== 1'b1 || exc_code !== 5'd7) begin
            errors++; $display("FAIL to_exc got %b/%0d want 1/7", exc_valid, exc_code);
        end
        checks++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL to_rdata got %h/%b stall %b want 0/0 0", rdata, rdata_valid, stall);
        end
        @(negedge clk);
        checks++;
        if (exc_valid !== 1'b0 || exc_code !== 5'd0) begin
            errors++; $display("FAIL to_clear got %b/%0d want 0/0", exc_valid, exc_code);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0300, 32'h0);
        @(negedge clk);
        clear_ops();
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL rst_busy2 got req %b stall %b want 1 1", bus_req, stall);
        end
        reset = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid got req %b stall %b valid %b want 0 0 0", bus_req, stall, rdata_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL rst_ack_ignored got req %b valid %b rd %h want 0 0 0", bus_req, rdata_valid, rdata);
        end
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_0304, 32'h0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_idle got stall %b want 1", stall); end
        @(negedge clk);
        clear_ops();
        bus_ack = 1'b1; bus_rdata = 32'h0;
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; op_load = 1'b0; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_faults();
        test_timeout_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
